// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the decode / write-back slice.
// Holds the instruction codes, the special register IDs and the datapath
// width used by decode_writeback and y86_regfile.
package y86_pkg;

    localparam int DATA_W = 64;
    localparam int NREGS  = 15;

    // Instruction codes as delivered by fetch.
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] ICMOVXX = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Special register IDs.
    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

endpackage

// File: rtl/y86_regfile.sv
// Y86-64 register file: NREGS x DATA_W, two registered read ports and two
// write ports (E and M).
//   clk, reset            : clock, synchronous active-high reset
//   rd_en                 : capture both read ports this cycle
//   rd_addr_a / rd_addr_b : read IDs (RNONE reads as zero)
//   we_e, addr_e, data_e  : E write port
//   we_m, addr_m, data_m  : M write port (wins over E on the same ID)
//   rd_data_a / rd_data_b : registered read data
// A read of an ID being written in the same cycle returns the new value
// (write-first), with the same M-over-E priority as the array update.
module y86_regfile #(
    parameter int DATA_W = 64,
    parameter int NREGS  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [3:0]        rd_addr_a,
    input  logic [3:0]        rd_addr_b,
    input  logic              we_e,
    input  logic [3:0]        addr_e,
    input  logic [DATA_W-1:0] data_e,
    input  logic              we_m,
    input  logic [3:0]        addr_m,
    input  logic [DATA_W-1:0] data_m,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b
);
    import y86_pkg::RNONE;

    logic [DATA_W-1:0] regs_r [NREGS];
    logic [DATA_W-1:0] rd_a_r, rd_b_r;
    logic [DATA_W-1:0] stored_a_s, stored_b_s;
    logic [DATA_W-1:0] rd_a_s, rd_b_s;
    logic              we_e_s, we_m_s;

    // ID F is never a real destination, so a write to it simply drops.
    assign we_e_s = we_e && (addr_e != RNONE);
    assign we_m_s = we_m && (addr_m != RNONE);

    // Resolve one read port: RNONE -> 0, else M hit, else E hit, else array.
    function automatic logic [DATA_W-1:0] bypass_read(
        input logic [3:0]        addr,
        input logic [DATA_W-1:0] stored,
        input logic              e_en,
        input logic [3:0]        e_addr,
        input logic [DATA_W-1:0] e_data,
        input logic              m_en,
        input logic [3:0]        m_addr,
        input logic [DATA_W-1:0] m_data
    );
        if (addr == RNONE) begin
            return '0;
        end else if (m_en && (m_addr == addr)) begin
            return m_data;
        end else if (e_en && (e_addr == addr)) begin
            return e_data;
        end else begin
            return stored;
        end
    endfunction

    // Array lookup for both read ports, then write-first bypass.
    always_comb begin
        stored_a_s = (rd_addr_a < 4'(NREGS)) ? regs_r[rd_addr_a] : '0;
        stored_b_s = (rd_addr_b < 4'(NREGS)) ? regs_r[rd_addr_b] : '0;
        rd_a_s = bypass_read(rd_addr_a, stored_a_s, we_e_s, addr_e, data_e,
                             we_m_s, addr_m, data_m);
        rd_b_s = bypass_read(rd_addr_b, stored_b_s, we_e_s, addr_e, data_e,
                             we_m_s, addr_m, data_m);
    end

    // Register array update and read-port capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= '0;
            end
            rd_a_r <= '0;
            rd_b_r <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (we_m_s && (addr_m == 4'(i))) begin
                    regs_r[i] <= data_m;
                end else if (we_e_s && (addr_e == 4'(i))) begin
                    regs_r[i] <= data_e;
                end
            end
            if (rd_en) begin
                rd_a_r <= rd_a_s;
                rd_b_r <= rd_b_s;
            end
        end
    end

    assign rd_data_a = rd_a_r;
    assign rd_data_b = rd_b_r;

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 SEQ decode and write-back stage.
// Derives srcA/srcB/dstE/dstM from fetch's icode/rA/rB, registers them on
// dec_en together with the operands read from the register file, and
// commits valE/valM on wb_en.
//   clk, reset                      : clock, synchronous active-high reset
//   dec_en, icode, ifun, rA, rB,
//   instr_valid                     : decode inputs from fetch
//   wb_en, wb_dstE, wb_dstM,
//   valE, valM, cnd                 : write-back inputs
//   srcA, srcB, dstE, dstM          : registered register IDs
//   valA, valB                      : registered operands
module decode_writeback #(
    parameter int DATA_W = 64,
    parameter int NREGS  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_en,
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic              instr_valid,
    input  logic              wb_en,
    input  logic [3:0]        wb_dstE,
    input  logic [3:0]        wb_dstM,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    input  logic              cnd,
    output logic [3:0]        srcA,
    output logic [3:0]        srcB,
    output logic [3:0]        dstE,
    output logic [3:0]        dstM,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB
);
    import y86_pkg::*;

    logic [3:0] src_a_s, src_b_s, dst_e_s, dst_m_s;
    logic [3:0] src_a_r, src_b_r, dst_e_r, dst_m_r;
    logic       wb_e_en_s;
    logic       unused_ifun_s;

    // The function code plays no part in register selection.
    assign unused_ifun_s = ^ifun;

    // A not-taken conditional move retires without updating its destination.
    assign wb_e_en_s = wb_en && !((icode == ICMOVXX) && !cnd);

    // Register ID selection from the instruction code.
    always_comb begin
        src_a_s = RNONE;
        src_b_s = RNONE;
        dst_e_s = RNONE;
        dst_m_s = RNONE;
        case (icode)
            ICMOVXX: begin src_a_s = rA;                   dst_e_s = rB;   end
            IIRMOVQ: begin                                 dst_e_s = rB;   end
            IRMMOVQ: begin src_a_s = rA;   src_b_s = rB;                   end
            IMRMOVQ: begin                 src_b_s = rB;   dst_m_s = rA;   end
            IOPQ:    begin src_a_s = rA;   src_b_s = rB;   dst_e_s = rB;   end
            ICALL:   begin                 src_b_s = RRSP; dst_e_s = RRSP; end
            IRET:    begin src_a_s = RRSP; src_b_s = RRSP; dst_e_s = RRSP; end
            IPUSHQ:  begin src_a_s = rA;   src_b_s = RRSP; dst_e_s = RRSP; end
            IPOPQ:   begin src_a_s = RRSP; src_b_s = RRSP; dst_e_s = RRSP;
                           dst_m_s = rA;                                   end
            default: begin src_a_s = RNONE;                                end
        endcase
        // An invalid slot reads nothing, so valA/valB also come out zero.
        if (!instr_valid) begin
            src_a_s = RNONE;
            src_b_s = RNONE;
            dst_e_s = RNONE;
            dst_m_s = RNONE;
        end else begin
            src_a_s = src_a_s;
        end
    end

    // Decoded ID registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_a_r <= RNONE;
            src_b_r <= RNONE;
            dst_e_r <= RNONE;
            dst_m_r <= RNONE;
        end else if (dec_en) begin
            src_a_r <= src_a_s;
            src_b_r <= src_b_s;
            dst_e_r <= dst_e_s;
            dst_m_r <= dst_m_s;
        end
    end

    y86_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .rd_en     (dec_en),
        .rd_addr_a (src_a_s),
        .rd_addr_b (src_b_s),
        .we_e      (wb_e_en_s),
        .addr_e    (wb_dstE),
        .data_e    (valE),
        .we_m      (wb_en),
        .addr_m    (wb_dstM),
        .data_m    (valM),
        .rd_data_a (valA),
        .rd_data_b (valB)
    );

    assign srcA = src_a_r;
    assign srcB = src_b_r;
    assign dstE = dst_e_r;
    assign dstM = dst_m_r;

endmodule

// File: tb/tb_decode_writeback.sv
// Directed testbench for decode_writeback.
module tb_decode_writeback;

    logic        clk = 1'b0;
    logic        reset, dec_en, instr_valid, wb_en, cnd;
    logic [3:0]  icode, ifun, rA, rB, wb_dstE, wb_dstM;
    logic [63:0] valE, valM;
    logic [3:0]  srcA, srcB, dstE, dstM;
    logic [63:0] valA, valB;

    int n_cmp  = 0;
    int n_fail = 0;

    decode_writeback dut (
        .clk(clk), .reset(reset), .dec_en(dec_en), .icode(icode), .ifun(ifun),
        .rA(rA), .rB(rB), .instr_valid(instr_valid), .wb_en(wb_en),
        .wb_dstE(wb_dstE), .wb_dstM(wb_dstM), .valE(valE), .valM(valM),
        .cnd(cnd), .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
        .valA(valA), .valB(valB)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; dec_en = 1'b0; instr_valid = 1'b1; wb_en = 1'b0; cnd = 1'b0;
        wb_dstE = 4'hF; wb_dstM = 4'hF; valE = 64'h0; valM = 64'h0;
    endtask

    task automatic drive_dec(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b);
        dec_en = 1'b1; instr_valid = 1'b1; icode = ic; rA = a; rB = b;
    endtask

    task automatic test_reset();
        idle(); icode = 4'h0; ifun = 4'h0; rA = 4'h0; rB = 4'h0;
        reset = 1'b1; tick(); tick(); idle();
        n_cmp++; if (srcA !== 4'hF) begin n_fail++; $display("FAIL reset_srcA got %h exp F", srcA); end
        n_cmp++; if (srcB !== 4'hF) begin n_fail++; $display("FAIL reset_srcB got %h exp F", srcB); end
        n_cmp++; if (dstE !== 4'hF) begin n_fail++; $display("FAIL reset_dstE got %h exp F", dstE); end
        n_cmp++; if (dstM !== 4'hF) begin n_fail++; $display("FAIL reset_dstM got %h exp F", dstM); end
        n_cmp++; if (valA !== 64'h0) begin n_fail++; $display("FAIL reset_valA got %h exp 0", valA); end
        n_cmp++; if (valB !== 64'h0) begin n_fail++; $display("FAIL reset_valB got %h exp 0", valB); end
    endtask

    task automatic test_opq_decode();
        idle(); drive_dec(4'h6, 4'h0, 4'h3); tick(); idle();
        n_cmp++; if (srcA !== 4'h0) begin n_fail++; $display("FAIL opq_srcA got %h exp 0", srcA); end
        n_cmp++; if (srcB !== 4'h3) begin n_fail++; $display("FAIL opq_srcB got %h exp 3", srcB); end
        n_cmp++; if (dstE !== 4'h3) begin n_fail++; $display("FAIL opq_dstE got %h exp 3", dstE); end
        n_cmp++; if (dstM !== 4'hF) begin n_fail++; $display("FAIL opq_dstM got %h exp F", dstM); end
        n_cmp++; if (valA !== 64'h0) begin n_fail++; $display("FAIL opq_valA got %h exp 0", valA); end
        n_cmp++; if (valB !== 64'h0) begin n_fail++; $display("FAIL opq_valB got %h exp 0", valB); end
    endtask

    task automatic test_writeback_read();
        idle(); icode = 4'h6; wb_en = 1'b1; wb_dstE = 4'h0; valE = 64'd12; tick(); idle();
        drive_dec(4'h6, 4'h0, 4'h3); tick(); idle();
        n_cmp++; if (valA !== 64'd12) begin n_fail++; $display("FAIL wb_read_valA got %h exp c", valA); end
        n_cmp++; if (valB !== 64'h0) begin n_fail++; $display("FAIL wb_read_valB got %h exp 0", valB); end
    endtask

    task automatic test_bypass();
        idle(); drive_dec(4'h6, 4'h5, 4'h0); wb_en = 1'b1; wb_dstE = 4'h5; valE = 64'h55; tick(); idle();
        n_cmp++; if (valA !== 64'h55) begin n_fail++; $display("FAIL bypass_valA got %h exp 55", valA); end
        n_cmp++; if (valB !== 64'd12) begin n_fail++; $display("FAIL bypass_valB got %h exp c", valB); end
    endtask

    task automatic test_popq_rsp();
        idle(); drive_dec(4'hB, 4'h4, 4'hF);
        wb_en = 1'b1; wb_dstE = 4'h4; valE = 64'h108; wb_dstM = 4'h4; valM = 64'h200; tick(); idle();
        n_cmp++; if (dstM !== 4'h4) begin n_fail++; $display("FAIL popq_dstM got %h exp 4", dstM); end
        n_cmp++; if (valA !== 64'h200) begin n_fail++; $display("FAIL popq_bypass_valA got %h exp 200", valA); end
        n_cmp++; if (valB !== 64'h200) begin n_fail++; $display("FAIL popq_bypass_valB got %h exp 200", valB); end
        drive_dec(4'hA, 4'h4, 4'hF); tick(); idle();
        n_cmp++; if (valA !== 64'h200) begin n_fail++; $display("FAIL popq_stored_valA got %h exp 200", valA); end
        n_cmp++; if (srcB !== 4'h4) begin n_fail++; $display("FAIL pushq_srcB got %h exp 4", srcB); end
    endtask

    task automatic test_cmov();
        idle(); icode = 4'h2; cnd = 1'b0; wb_en = 1'b1; wb_dstE = 4'h2; valE = 64'd7; tick(); idle();
        drive_dec(4'h6, 4'h2, 4'h5); tick(); idle();
        n_cmp++; if (valA !== 64'h0) begin n_fail++; $display("FAIL cmov_nottaken got %h exp 0", valA); end
        n_cmp++; if (valB !== 64'h55) begin n_fail++; $display("FAIL cmov_r5 got %h exp 55", valB); end
        icode = 4'h2; cnd = 1'b1; wb_en = 1'b1; wb_dstE = 4'h2; valE = 64'd7; tick(); idle();
        drive_dec(4'h6, 4'h2, 4'h5); tick(); idle();
        n_cmp++; if (valA !== 64'd7) begin n_fail++; $display("FAIL cmov_taken got %h exp 7", valA); end
        // Suppressed write must not be forwarded to a same-cycle read.
        drive_dec(4'h2, 4'h2, 4'h6); cnd = 1'b0; wb_en = 1'b1; wb_dstE = 4'h2; valE = 64'd9; tick(); idle();
        n_cmp++; if (valA !== 64'd7) begin n_fail++; $display("FAIL cmov_nobypass got %h exp 7", valA); end
        n_cmp++; if (dstE !== 4'h6) begin n_fail++; $display("FAIL cmov_dstE got %h exp 6", dstE); end
        n_cmp++; if (srcB !== 4'hF) begin n_fail++; $display("FAIL cmov_srcB got %h exp F", srcB); end
    endtask

    task automatic test_id_table();
        // {icode, srcA, srcB, dstE, dstM} with rA=1, rB=2
        logic [19:0] vec [13];
        logic [19:0] v;
        vec[0]  = 20'h0FFFF; vec[1]  = 20'h1FFFF; vec[2]  = 20'h21F2F; vec[3]  = 20'h3FF2F;
        vec[4]  = 20'h412FF; vec[5]  = 20'h5F2F1; vec[6]  = 20'h6122F; vec[7]  = 20'h7FFFF;
        vec[8]  = 20'h8F44F; vec[9]  = 20'h9444F; vec[10] = 20'hA144F; vec[11] = 20'hB4441;
        vec[12] = 20'hCFFFF;
        for (int i = 0; i < 13; i++) begin
            v = vec[i];
            idle(); drive_dec(v[19:16], 4'h1, 4'h2); tick(); idle();
            n_cmp++; if ({srcA, srcB, dstE, dstM} !== v[15:0]) begin
                n_fail++; $display("FAIL ids_icode_%h got %h exp %h", v[19:16], {srcA, srcB, dstE, dstM}, v[15:0]);
            end
        end
    endtask

    task automatic test_hold();
        idle(); drive_dec(4'h6, 4'h5, 4'h2); tick(); idle();
        icode = 4'h9; rA = 4'h0; rB = 4'h0; tick(); tick();
        n_cmp++; if ({srcA, srcB, dstE} !== 12'h522) begin n_fail++; $display("FAIL hold_ids got %h exp 522", {srcA, srcB, dstE}); end
        n_cmp++; if (valA !== 64'h55) begin n_fail++; $display("FAIL hold_valA got %h exp 55", valA); end
        n_cmp++; if (valB !== 64'd7) begin n_fail++; $display("FAIL hold_valB got %h exp 7", valB); end
    endtask

    task automatic test_invalid_and_f();
        idle(); icode = 4'h6; wb_en = 1'b1; wb_dstE = 4'h1; valE = 64'h33;
        wb_dstM = 4'hF; valM = 64'hBEEF; tick(); idle();
        wb_en = 1'b1; wb_dstE = 4'hF; valE = 64'hDEAD; tick(); idle();
        drive_dec(4'h6, 4'h1, 4'h0); tick(); idle();
        n_cmp++; if (valA !== 64'h33) begin n_fail++; $display("FAIL fwrite_r1 got %h exp 33", valA); end
        n_cmp++; if (valB !== 64'd12) begin n_fail++; $display("FAIL fwrite_r0 got %h exp c", valB); end
        drive_dec(4'h6, 4'h1, 4'h2); instr_valid = 1'b0; tick(); idle();
        n_cmp++; if ({srcA, srcB, dstE, dstM} !== 16'hFFFF) begin n_fail++; $display("FAIL invalid_ids got %h exp ffff", {srcA, srcB, dstE, dstM}); end
        n_cmp++; if (valA !== 64'h0) begin n_fail++; $display("FAIL invalid_valA got %h exp 0", valA); end
        n_cmp++; if (valB !== 64'h0) begin n_fail++; $display("FAIL invalid_valB got %h exp 0", valB); end
    endtask

    task automatic test_reset_mid();
        idle(); drive_dec(4'h6, 4'h1, 4'h0); reset = 1'b1;
        wb_en = 1'b1; wb_dstE = 4'h1; valE = 64'd9; tick(); idle();
        n_cmp++; if ({srcA, srcB, dstE, dstM} !== 16'hFFFF) begin n_fail++; $display("FAIL rstmid_ids got %h exp ffff", {srcA, srcB, dstE, dstM}); end
        n_cmp++; if (valA !== 64'h0) begin n_fail++; $display("FAIL rstmid_valA got %h exp 0", valA); end
        drive_dec(4'h6, 4'h1, 4'h0); tick(); idle();
        n_cmp++; if (valA !== 64'h0) begin n_fail++; $display("FAIL rstmid_r1 got %h exp 0", valA); end
        n_cmp++; if (valB !== 64'h0) begin n_fail++; $display("FAIL rstmid_r0 got %h exp 0", valB); end
        drive_dec(4'hA, 4'h5, 4'h0); tick(); idle();
        n_cmp++; if (valB !== 64'h0) begin n_fail++; $display("FAIL rstmid_rsp got %h exp 0", valB); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_opq_decode();
        test_writeback_read();
        test_bypass();
        test_popq_rsp();
        test_cmov();
        test_id_table();
        test_hold();
        test_invalid_and_f();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
